// File: rtl/noc_packet_injector_pkg.sv
// ---------------------------------------------------------------------------
// noc_packet_injector_pkg
// Shared definitions for the NoC packet injector: flit type encodings,
// header destination field position, flit width arithmetic and the FSM
// state type.
// ---------------------------------------------------------------------------
package noc_packet_injector_pkg;

  // Flit type encodings carried in the top bits of every flit.
  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  // Destination field inside the header word.
  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 27;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DROP = 2'd1,
    SEND = 2'd2
  } state_t;

  function automatic int flit_width(input int data_w, input int type_w);
    return data_w + type_w;
  endfunction

  function automatic logic [DEST_MSB-DEST_LSB:0] hdr_dest(input logic [31:0] hdr);
    return hdr[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/noc_packet_injector_buffer.sv
// ---------------------------------------------------------------------------
// noc_packet_buffer
// MAX_LEN x DATA_W register file holding one packet.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   wr_addr  in   write index
//   wr_data  in   write word
//   rd_addr  in   read index (combinational read)
//   rd_data  out  word at rd_addr
// ---------------------------------------------------------------------------
module noc_packet_buffer
  import noc_packet_injector_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 8,
  localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Packet payload storage; contents need no reset because every word is
  // written before it can be read.
  logic [DATA_W-1:0] mem [0:MAX_LEN-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/noc_packet_injector.sv
// ---------------------------------------------------------------------------
// noc_packet_injector
// Store-and-forward packet transmitter onto one virtual channel of a lisnoc
// mesh link. Buffers a complete packet from a 32-bit word stream, then
// serialises it as typed flits (HEADER/PAYLOAD/LAST or SINGLE).
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   in_data        in   packet word (first word = header, dest in [31:27])
//   in_valid       in   in_data valid
//   in_last        in   final word of packet
//   in_ready       out  word accepted when in_valid && in_ready
//   noc_out_flit   out  {type, data}
//   noc_out_valid  out  one-hot on VC_SEL while sending
//   noc_out_ready  in   link ready per VC (only VC_SEL observed)
//   busy           out  high while sending
//   err_overflow   out  one-cycle pulse when a packet is truncated
// ---------------------------------------------------------------------------
module noc_packet_injector
  import noc_packet_injector_pkg::*;
#(
  parameter int NOC_DATA_WIDTH = 32,
  parameter int NOC_TYPE_WIDTH = 2,
  parameter int VCHANNELS      = 3,
  parameter int VC_SEL         = 0,
  parameter int MAX_LEN        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NOC_DATA_WIDTH-1:0] in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [flit_width(NOC_DATA_WIDTH, NOC_TYPE_WIDTH)-1:0] noc_out_flit,
  output logic [VCHANNELS-1:0]      noc_out_valid,
  input  logic [VCHANNELS-1:0]      noc_out_ready,
  output logic                      busy,
  output logic                      err_overflow
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LEN - 1);
  localparam logic [CW-1:0] FULL_LEN = CW'(MAX_LEN);

  state_t              state, state_n;
  logic [CW-1:0]       wr_cnt, wr_cnt_n;
  logic [CW-1:0]       rd_idx, rd_idx_n;
  logic [CW-1:0]       len, len_n;
  logic                ovf_n;
  logic                buf_we;
  logic                send_vld;
  logic                link_ready;
  logic [NOC_TYPE_WIDTH-1:0] flit_type;
  logic [NOC_DATA_WIDTH-1:0] rd_data;

  // Other VCs' ready lines belong to traffic this block never drives.
  logic unused_ready;
  assign unused_ready = ^noc_out_ready;

  assign link_ready = noc_out_ready[VC_SEL];

  noc_packet_buffer #(
    .DATA_W  (NOC_DATA_WIDTH),
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_idx[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FILL;
      wr_cnt       <= '0;
      rd_idx       <= '0;
      len          <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_n;
      wr_cnt       <= wr_cnt_n;
      rd_idx       <= rd_idx_n;
      len          <= len_n;
      err_overflow <= ovf_n;
    end
  end

  always_comb begin
    state_n  = state;
    wr_cnt_n = wr_cnt;
    rd_idx_n = rd_idx;
    len_n    = len;
    ovf_n    = 1'b0;
    buf_we   = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    send_vld = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we   = 1'b1;
          wr_cnt_n = wr_cnt + ONE;
          if (in_last) begin
            len_n   = wr_cnt + ONE;
            state_n = SEND;
          end else if (wr_cnt == LAST_IDX) begin
            // Buffer full without an end marker: keep what fits and
            // swallow the rest of the packet.
            len_n   = FULL_LEN;
            ovf_n   = 1'b1;
            state_n = DROP;
          end
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_n = SEND;
        end
      end
      SEND: begin
        busy     = 1'b1;
        send_vld = 1'b1;
        if (link_ready) begin
          if (rd_idx == len - ONE) begin
            rd_idx_n = '0;
            wr_cnt_n = '0;
            state_n  = FILL;
          end else begin
            rd_idx_n = rd_idx + ONE;
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_comb begin
    if (len == ONE) begin
      flit_type = NOC_TYPE_WIDTH'(FLIT_SINGLE);
    end else if (rd_idx == '0) begin
      flit_type = NOC_TYPE_WIDTH'(FLIT_HEADER);
    end else if (rd_idx == len - ONE) begin
      flit_type = NOC_TYPE_WIDTH'(FLIT_LAST);
    end else begin
      flit_type = NOC_TYPE_WIDTH'(FLIT_PAYLOAD);
    end
  end

  always_comb begin
    noc_out_valid         = '0;
    noc_out_valid[VC_SEL] = send_vld;
    noc_out_flit          = '0;
    if (send_vld) begin
      noc_out_flit = {flit_type, rd_data};
    end
  end

endmodule
